// File: rtl/slc3_mem_ctrl.sv
// SLC-3 memory/IO controller: turns FSM level strobes into single BRAM
// accesses, signals completion with Mem_Ready and maps IO_ADDR to SW/HEX.
module slc3_mem_ctrl #(
   parameter int          READ_LAT = 2,
   parameter int          ADDR_W   = 16,
   parameter logic [15:0] IO_ADDR  = 16'hFFFF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Mem_OE,
   input  logic              Mem_WE,
   input  logic [15:0]       ADDR,
   input  logic [15:0]       Data_from_CPU,
   output logic [15:0]       Data_to_CPU,
   output logic              Mem_Ready,
   input  logic [15:0]       SW,
   output logic [15:0]       HEX_Disp,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [15:0]       bram_din,
   input  logic [15:0]       bram_dout,
   output logic              bram_we
);

   localparam int CW = $clog2(READ_LAT + 1);
   localparam logic [CW-1:0] LAT = CW'(READ_LAT);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_WAIT,
      DONE,
      HOLD
   } state_t;

   state_t state, state_n;

   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       sw_meta, sw_sync;
   logic              is_io;
   logic              wr_io, wr_bram, rd_io, rd_bram;

   // WE wins over OE, so the four request kinds are mutually exclusive
   assign is_io   = (ADDR == IO_ADDR);
   assign wr_io   = Mem_WE & is_io;
   assign wr_bram = Mem_WE & ~is_io;
   assign rd_io   = ~Mem_WE & Mem_OE & is_io;
   assign rd_bram = ~Mem_WE & Mem_OE & ~is_io;

   assign bram_addr = addr_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         cnt         <= '0;
         addr_q      <= '0;
         bram_din    <= '0;
         Data_to_CPU <= '0;
         HEX_Disp    <= '0;
         sw_meta     <= '0;
         sw_sync     <= '0;
      end else begin
         state   <= state_n;
         sw_meta <= SW;
         sw_sync <= sw_meta;
         unique case (state)
            IDLE: begin
               unique case (1'b1)
                  wr_io:   HEX_Disp <= Data_from_CPU;
                  wr_bram: begin
                     addr_q   <= ADDR[ADDR_W-1:0];
                     bram_din <= Data_from_CPU;
                  end
                  rd_io:   Data_to_CPU <= sw_sync;
                  rd_bram: begin
                     addr_q <= ADDR[ADDR_W-1:0];
                     cnt    <= '0;
                  end
                  default: ;
               endcase
            end
            RD_WAIT: begin
               cnt <= cnt + CW'(1);
               if (cnt == LAT)
                  Data_to_CPU <= bram_dout;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_n   = state;
      bram_we   = 1'b0;
      Mem_Ready = 1'b0;
      unique case (state)
         IDLE: begin
            unique case (1'b1)
               wr_io:   state_n = DONE;
               wr_bram: state_n = WR;
               rd_io:   state_n = DONE;
               rd_bram: state_n = RD_WAIT;
               default: ;
            endcase
         end
         WR: begin
            bram_we = 1'b1;
            state_n = DONE;
         end
         RD_WAIT: begin
            if (cnt == LAT)
               state_n = DONE;
         end
         DONE: begin
            Mem_Ready = 1'b1;
            state_n   = (Mem_OE | Mem_WE) ? HOLD : IDLE;
         end
         HOLD: begin
            if (!Mem_OE && !Mem_WE)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Directed bench for slc3_mem_ctrl: BRAM model with 2-cycle read latency,
// scoreboard of expected Data_to_CPU per access.
module tb_slc3_mem_ctrl;

   logic        Clk = 0;
   logic        Reset = 1;
   logic        Mem_OE = 0, Mem_WE = 0;
   logic [15:0] ADDR = 0, Data_from_CPU = 0;
   logic [15:0] Data_to_CPU;
   logic        Mem_Ready;
   logic [15:0] SW = 0;
   logic [15:0] HEX_Disp;
   logic [15:0] bram_addr, bram_din, bram_dout;
   logic        bram_we;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:65535];
   logic [15:0] rd1;
   logic [15:0] model [int];
   logic [15:0] sb [$];
   logic [15:0] last_rd = 0;
   logic [15:0] hex_model = 0;
   logic [15:0] addr_model = 0;
   logic [15:0] sw_model = 0;

   always #5 Clk = ~Clk;

   slc3_mem_ctrl dut (
      .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
      .Data_to_CPU(Data_to_CPU), .Mem_Ready(Mem_Ready), .SW(SW),
      .HEX_Disp(HEX_Disp), .bram_addr(bram_addr), .bram_din(bram_din),
      .bram_dout(bram_dout), .bram_we(bram_we)
   );

   // synchronous RAM plus output register: 2 cycles address to data
   always @(posedge Clk) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      rd1       <= mem[bram_addr];
      bram_dout <= rd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic access(input string tag, input logic we, input logic oe,
                         input logic [15:0] a, input logic [15:0] d,
                         input int lat, input int hold);
      int rdy_first, rdy_n, we_n;
      logic [15:0] a1, h1;
      logic io, exp_we;
      io = (a == 16'hFFFF);
      exp_we = we && !io;
      rdy_first = -1; rdy_n = 0; we_n = 0;
      @(negedge Clk);
      ADDR = a; Data_from_CPU = d; Mem_WE = we; Mem_OE = oe;
      if (we) begin
         sb.push_back(last_rd);
         if (io) hex_model = d;
         else begin model[a] = d; addr_model = a; end
      end else begin
         if (io) sb.push_back(sw_model);
         else begin sb.push_back(model[a]); addr_model = a; end
      end
      for (int k = 1; k <= 10; k++) begin
         @(posedge Clk); #1;
         if (Mem_Ready) begin
            rdy_n++;
            if (rdy_first < 0) rdy_first = k;
            chk({tag, ".data"}, Data_to_CPU, sb.pop_front());
            last_rd = Data_to_CPU;
         end
         if (bram_we) we_n++;
         if (k == 1) begin
            a1 = bram_addr; h1 = HEX_Disp;
            ADDR = ~a; Data_from_CPU = ~d;
         end
         if (k >= hold) begin Mem_WE = 0; Mem_OE = 0; end
      end
      chk({tag, ".rdy_cycle"}, rdy_first, lat);
      chk({tag, ".rdy_count"}, rdy_n, 1);
      chk({tag, ".we_count"}, we_n, {31'd0, exp_we});
      chk({tag, ".addr_c1"}, a1, addr_model);
      chk({tag, ".hex"}, HEX_Disp, hex_model);
      if (we && io) chk({tag, ".hex_c1"}, h1, d);
      if (rdy_n == 0) void'(sb.pop_front());
   endtask

   initial begin
      int rdy_seen;
      mem[16'h0010]   = 16'h1234;
      model[16'h0010] = 16'h1234;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst.data", Data_to_CPU, 0);
      chk("rst.ready", Mem_Ready, 0);
      chk("rst.hex", HEX_Disp, 0);
      chk("rst.addr", bram_addr, 0);
      chk("rst.we", bram_we, 0);
      @(negedge Clk); Reset = 0;

      access("rd10", 0, 1, 16'h0010, 0, 4, 4);
      access("wr20", 1, 0, 16'h0020, 16'hBEEF, 2, 5);
      access("rb20", 0, 1, 16'h0020, 0, 4, 4);

      @(negedge Clk); SW = 16'h00A5;
      repeat (3) @(posedge Clk);
      sw_model = 16'h00A5;
      access("rdsw", 0, 1, 16'hFFFF, 0, 1, 1);
      access("wrhex", 1, 0, 16'hFFFF, 16'h1F2E, 1, 1);
      access("oewe", 1, 1, 16'h0030, 16'h5A5A, 2, 2);
      access("rb30", 0, 1, 16'h0030, 0, 4, 4);

      // reset in the middle of a BRAM read
      @(negedge Clk);
      ADDR = 16'h0010; Mem_OE = 1;
      @(posedge Clk); #1;
      @(negedge Clk); Mem_OE = 0; Reset = 1;
      @(posedge Clk); #1;
      @(negedge Clk); Reset = 0;
      chk("mid.data", Data_to_CPU, 0);
      chk("mid.hex", HEX_Disp, 0);
      chk("mid.addr", bram_addr, 0);
      chk("mid.din", bram_din, 0);
      rdy_seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge Clk); #1;
         if (Mem_Ready) rdy_seen++;
      end
      chk("mid.no_ready", rdy_seen, 0);
      last_rd = 0; hex_model = 0; addr_model = 0;
      access("post", 0, 1, 16'h0010, 0, 4, 4);

      chk("sb.empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
